// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline execution controller and the debug front end.
package pipeline_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CMD_W   = 2;
  localparam int unsigned DRAIN_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 3'd1;
  localparam logic [STATE_W-1:0] ST_STEP  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  localparam logic [CMD_W-1:0] CMD_NOP   = 2'b00;
  localparam logic [CMD_W-1:0] CMD_RUN   = 2'b01;
  localparam logic [CMD_W-1:0] CMD_STEP  = 2'b10;
  localparam logic [CMD_W-1:0] CMD_ABORT = 2'b11;

  // Enough drain cycles for HALT in ID to retire through WB.
  localparam int unsigned DRAIN_CYCLES_DEF = 4;

  function automatic logic state_enabled(input logic [STATE_W-1:0] st);
    return (st == ST_RUN) || (st == ST_STEP) || (st == ST_DRAIN);
  endfunction

  function automatic logic state_ready(input logic [STATE_W-1:0] st);
    return (st == ST_IDLE) || (st == ST_RUN) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// Command/status bundle between the debug front end and the execution controller.
interface pipeline_exec_ctrl_if #(
  parameter int unsigned CNT_BITS = 32
);
  import pipeline_ctrl_pkg::*;

  logic                 i_cmd_valid;
  logic [CMD_W-1:0]     i_cmd;
  logic                 o_cmd_ready;
  logic                 i_halt_id;
  logic                 o_pipe_en;
  logic                 o_busy;
  logic                 o_step_ack;
  logic                 o_done;
  logic [STATE_W-1:0]   o_state;
  logic [CNT_BITS-1:0]  o_cycle_count;

  modport master (
    output i_cmd_valid, i_cmd, i_halt_id,
    input  o_cmd_ready, o_pipe_en, o_busy, o_step_ack, o_done, o_state, o_cycle_count
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_halt_id,
    output o_cmd_ready, o_pipe_en, o_busy, o_step_ack, o_done, o_state, o_cycle_count
  );

endinterface

// File: rtl/exec_cycle_counter.sv
// Saturating cycle counter with enable and synchronous clear (clear has priority).
module exec_cycle_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Run / single-step / halt-drain sequencer producing the global pipeline enable.
module pipeline_exec_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  pipeline_exec_ctrl_if.slave   bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               pipe_en_q;
  logic               cmd_ready_q;
  logic               step_ack_q, step_ack_d;
  logic               done_q, done_d;
  logic               cmd_acc_c;
  logic               cnt_clr_c;

  // Next-state and pulse decisions.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    step_ack_d = 1'b0;
    cnt_clr_c  = 1'b0;
    cmd_acc_c  = bus.i_cmd_valid && cmd_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_acc_c) begin
          case (bus.i_cmd)
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        // ABORT outranks a simultaneous HALT.
        if (cmd_acc_c && (bus.i_cmd == CMD_ABORT)) begin
          state_d = ST_IDLE;
        end else if (bus.i_halt_id) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      ST_STEP: begin
        if (bus.i_halt_id) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end else begin
          state_d    = ST_IDLE;
          step_ack_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q <= DRAIN_W'(1)) begin
          state_d = ST_DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        if (cmd_acc_c && (bus.i_cmd == CMD_ABORT)) begin
          state_d   = ST_IDLE;
          cnt_clr_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase

    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // State and registered output decodes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      pipe_en_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      step_ack_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      pipe_en_q   <= state_enabled(state_d);
      cmd_ready_q <= state_ready(state_d);
      step_ack_q  <= step_ack_d;
      done_q      <= done_d;
    end
  end

  exec_cycle_counter #(
    .WIDTH (CNT_BITS)
  ) u_cycle_counter (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (pipe_en_q),
    .clr   (cnt_clr_c),
    .count (bus.o_cycle_count)
  );

  assign bus.o_pipe_en   = pipe_en_q;
  assign bus.o_busy      = pipe_en_q;
  assign bus.o_cmd_ready = cmd_ready_q;
  assign bus.o_step_ack  = step_ack_q;
  assign bus.o_done      = done_q;
  assign bus.o_state     = state_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Randomized scenario bench for pipeline_exec_ctrl, checked against scenario-level arithmetic.
module tb_pipeline_exec_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned DRAIN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipeline_exec_ctrl_if #(.CNT_BITS(32)) bus ();
  pipeline_exec_ctrl_if #(.CNT_BITS(4))  bus4 ();

  pipeline_exec_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_BITS(32)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  pipeline_exec_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_BITS(4)) dut4 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus4.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  longint unsigned exp_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse/enable tallies sampled mid-cycle, plus per-cycle output invariants.
  int en_tot = 0, ack_tot = 0, done_tot = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      en_tot   += int'(bus.o_pipe_en);
      ack_tot  += int'(bus.o_step_ack);
      done_tot += int'(bus.o_done);
      check_eq("busy_eq_en", 64'(bus.o_busy), 64'(bus.o_pipe_en));
      check_eq("ack_done_excl", 64'(bus.o_step_ack & bus.o_done), 64'(0));
      check_eq("en_vs_state", 64'(bus.o_pipe_en), 64'(bus.o_state inside {3'd1, 3'd2, 3'd3}));
      check_eq("ready_vs_state", 64'(bus.o_cmd_ready), 64'(bus.o_state inside {3'd0, 3'd1, 3'd4}));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    cyc();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = CMD_NOP;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (bus.o_state !== s && n < budget) begin
      cyc();
      n++;
    end
    check_eq(tag, 64'(bus.o_state), 64'(s));
  endtask

  // Harmless traffic in IDLE: NOP/ABORT commands and stray HALT are all no-ops there.
  task automatic idle_noise();
    repeat ($urandom_range(0, 3)) begin
      bus.i_cmd_valid = 1'($urandom_range(0, 1));
      bus.i_cmd       = ($urandom_range(0, 1) != 0) ? CMD_NOP : CMD_ABORT;
      bus.i_halt_id   = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = CMD_NOP;
    bus.i_halt_id   = 1'b0;
    check_eq("idle_noise_count", 64'(bus.o_cycle_count), 64'(exp_cnt));
  endtask

  // Clear DONE with ABORT; RUN first must be dropped.
  task automatic leave_done();
    send(CMD_RUN);
    cyc();
    check_eq("done_run_dropped", 64'(bus.o_state), 64'(ST_DONE));
    send(CMD_ABORT);
    check_eq("done_abort_state", 64'(bus.o_state), 64'(ST_IDLE));
    check_eq("done_abort_clear", 64'(bus.o_cycle_count), 64'(0));
    exp_cnt = 0;
  endtask

  task automatic run_halt(input int k);
    int e0 = en_tot, a0 = ack_tot, d0 = done_tot;
    send(CMD_RUN);
    for (int i = 0; i < k - 1; i++) begin
      bus.i_cmd_valid = 1'($urandom_range(0, 1));
      bus.i_cmd       = ($urandom_range(0, 1) != 0) ? CMD_RUN : CMD_STEP;
      cyc();
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_halt_id   = 1'b1;
    cyc();
    // During drain, ABORT is not accepted and HALT is ignored.
    for (int i = 0; i < int'(DRAIN); i++) begin
      bus.i_halt_id   = 1'($urandom_range(0, 1));
      bus.i_cmd_valid = 1'($urandom_range(0, 1));
      bus.i_cmd       = CMD_ABORT;
      cyc();
    end
    bus.i_halt_id   = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = CMD_NOP;
    wait_state("run_reach_done", ST_DONE, 40);
    repeat (3) cyc();
    exp_cnt += longint'(k) + longint'(DRAIN);
    check_eq("run_en_cycles", 64'(en_tot - e0), 64'(k + int'(DRAIN)));
    check_eq("run_done_pulses", 64'(done_tot - d0), 64'(1));
    check_eq("run_ack_pulses", 64'(ack_tot - a0), 64'(0));
    check_eq("run_count", 64'(bus.o_cycle_count), 64'(exp_cnt));
    check_eq("run_pipe_off", 64'(bus.o_pipe_en), 64'(0));
    leave_done();
  endtask

  task automatic steps(input int n);
    int e0 = en_tot, a0 = ack_tot, d0 = done_tot;
    for (int i = 0; i < n; i++) begin
      send(CMD_STEP);
      cyc();
    end
    repeat (2) cyc();
    exp_cnt += longint'(n);
    check_eq("step_en_cycles", 64'(en_tot - e0), 64'(n));
    check_eq("step_ack_pulses", 64'(ack_tot - a0), 64'(n));
    check_eq("step_done_pulses", 64'(done_tot - d0), 64'(0));
    check_eq("step_state", 64'(bus.o_state), 64'(ST_IDLE));
    check_eq("step_count", 64'(bus.o_cycle_count), 64'(exp_cnt));
  endtask

  task automatic step_halt();
    int e0 = en_tot, a0 = ack_tot, d0 = done_tot;
    bus.i_halt_id = 1'b1;
    send(CMD_STEP);
    cyc();
    bus.i_halt_id = 1'b0;
    wait_state("stephalt_reach_done", ST_DONE, 20);
    repeat (3) cyc();
    exp_cnt += 64'(1 + DRAIN);
    check_eq("stephalt_en_cycles", 64'(en_tot - e0), 64'(1 + int'(DRAIN)));
    check_eq("stephalt_done_pulses", 64'(done_tot - d0), 64'(1));
    check_eq("stephalt_ack_pulses", 64'(ack_tot - a0), 64'(0));
    check_eq("stephalt_count", 64'(bus.o_cycle_count), 64'(exp_cnt));
    leave_done();
  endtask

  task automatic run_abort(input int k);
    int e0 = en_tot, d0 = done_tot;
    send(CMD_RUN);
    repeat (k - 1) cyc();
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = CMD_ABORT;
    bus.i_halt_id   = 1'b1;
    cyc();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = CMD_NOP;
    bus.i_halt_id   = 1'b0;
    check_eq("abort_state", 64'(bus.o_state), 64'(ST_IDLE));
    repeat (2) cyc();
    exp_cnt += longint'(k);
    check_eq("abort_no_drain", 64'(en_tot - e0), 64'(k));
    check_eq("abort_done_pulses", 64'(done_tot - d0), 64'(0));
    check_eq("abort_count_kept", 64'(bus.o_cycle_count), 64'(exp_cnt));
    send(CMD_ABORT);
    cyc();
    check_eq("idle_abort_count", 64'(bus.o_cycle_count), 64'(exp_cnt));
  endtask

  initial begin
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = CMD_NOP;
    bus.i_halt_id    = 1'b0;
    bus4.i_cmd_valid = 1'b0;
    bus4.i_cmd       = CMD_NOP;
    bus4.i_halt_id   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pipe_en", 64'(bus.o_pipe_en), 64'(0));
    check_eq("rst_busy", 64'(bus.o_busy), 64'(0));
    check_eq("rst_step_ack", 64'(bus.o_step_ack), 64'(0));
    check_eq("rst_done", 64'(bus.o_done), 64'(0));
    check_eq("rst_state", 64'(bus.o_state), 64'(ST_IDLE));
    check_eq("rst_count", 64'(bus.o_cycle_count), 64'(0));
    check_eq("rst_ready", 64'(bus.o_cmd_ready), 64'(1));
    rst_n = 1'b1;
    cyc();

    run_halt(10);
    steps(3);
    step_halt();
    run_abort(5);

    repeat (14) begin
      idle_noise();
      case ($urandom_range(0, 3))
        0:       run_halt(int'($urandom_range(1, 25)));
        1:       steps(int'($urandom_range(1, 4)));
        2:       step_halt();
        default: run_abort(int'($urandom_range(1, 20)));
      endcase
    end

    // Reset in the middle of a drain.
    begin
      int d0;
      send(CMD_RUN);
      repeat (3) cyc();
      bus.i_halt_id = 1'b1;
      cyc();
      bus.i_halt_id = 1'b0;
      cyc();
      check_eq("pre_reset_drain", 64'(bus.o_state), 64'(ST_DRAIN));
      rst_n = 1'b0;
      #1;
      check_eq("midrst_pipe_en", 64'(bus.o_pipe_en), 64'(0));
      check_eq("midrst_busy", 64'(bus.o_busy), 64'(0));
      check_eq("midrst_done", 64'(bus.o_done), 64'(0));
      check_eq("midrst_ack", 64'(bus.o_step_ack), 64'(0));
      check_eq("midrst_state", 64'(bus.o_state), 64'(ST_IDLE));
      check_eq("midrst_count", 64'(bus.o_cycle_count), 64'(0));
      cyc();
      cyc();
      rst_n = 1'b1;
      d0 = done_tot;
      repeat (6) cyc();
      exp_cnt = 0;
      check_eq("postrst_state", 64'(bus.o_state), 64'(ST_IDLE));
      check_eq("postrst_pipe_en", 64'(bus.o_pipe_en), 64'(0));
      check_eq("postrst_count", 64'(bus.o_cycle_count), 64'(exp_cnt));
      check_eq("postrst_no_done", 64'(done_tot - d0), 64'(0));
    end

    // Narrow counter saturates at all-ones.
    bus4.i_cmd_valid = 1'b1;
    bus4.i_cmd       = CMD_RUN;
    cyc();
    bus4.i_cmd_valid = 1'b0;
    repeat (20) cyc();
    check_eq("sat_running", 64'(bus4.o_pipe_en), 64'(1));
    check_eq("sat_count", 64'(bus4.o_cycle_count), 64'(15));
    repeat (5) cyc();
    check_eq("sat_hold", 64'(bus4.o_cycle_count), 64'(15));
    bus4.i_cmd_valid = 1'b1;
    bus4.i_cmd       = CMD_ABORT;
    cyc();
    bus4.i_cmd_valid = 1'b0;
    cyc();
    check_eq("sat_abort_state", 64'(bus4.o_state), 64'(ST_IDLE));
    check_eq("sat_abort_kept", 64'(bus4.o_cycle_count), 64'(15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
- Execution controller for the MIPS pipeline; sequences run, single-step and halt-drain of the whole datapath.
- Drives one global enable that gates PC and every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB), ANDed downstream with the hazard unit's PC/IF-ID write controls.
- Accepts commands from the debug front end and detects HALT decoded in ID.
- Lets HALT drain to WB, then freezes the datapath and reports completion and cycle count.

Parameters:
- DRAIN_CYCLES, 4, enabled cycles after HALT is seen in ID before freezing; legal range 1..15.
- CNT_BITS, 32, width of the executed-cycle counter.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command present.
- i_cmd  in  2  command: 00 NOP, 01 RUN, 10 STEP, 11 ABORT.
- o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready at a clock edge.
- i_halt_id  in  1  HALT instruction currently decoded in ID.
- o_pipe_en  out  1  global enable for PC and all pipeline latches.
- o_busy  out  1  state is RUN, STEP or DRAIN.
- o_step_ack  out  1  one-cycle pulse when a STEP completes without HALT.
- o_done  out  1  one-cycle pulse on entry to DONE.
- o_state  out  3  current state encoding, for debug readout.
- o_cycle_count  out  CNT_BITS  number of cycles with o_pipe_en=1 since the last clear.

Behaviour:
- Reset (async, i_reset_n=0):
  - State=IDLE; drain counter=0; o_cycle_count=0.
  - o_pipe_en=0, o_busy=0, o_step_ack=0, o_done=0, o_state=0.
  - Reset mid-RUN or mid-DRAIN aborts immediately; no pulses are emitted.
- State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4. All outputs are registered or pure decodes of registered state.
- o_pipe_en=1 exactly in RUN, STEP, DRAIN. o_busy equals o_pipe_en.
- o_cmd_ready=1 in IDLE, RUN and DONE; 0 in STEP and DRAIN.
- Command latency: an accepted command changes state at that edge, so o_pipe_en rises the cycle after acceptance.
- IDLE:
  - RUN → RUN.
  - STEP → STEP.
  - ABORT and NOP: stay in IDLE; count unchanged.
- RUN:
  - o_cycle_count increments each cycle.
  - Accepted ABORT → IDLE; count is kept.
  - Else i_halt_id=1 → DRAIN; drain counter loaded with DRAIN_CYCLES.
  - RUN and STEP commands are accepted and ignored.
  - ABORT and HALT in the same cycle: ABORT wins.
- STEP:
  - Exactly one enabled cycle; count increments.
  - If i_halt_id=1 in that cycle → DRAIN; else → IDLE with o_step_ack=1 for the next cycle.
- DRAIN:
  - Enabled for exactly DRAIN_CYCLES cycles; count increments each cycle.
  - Drain counter decrements; at 1 → DONE.
  - i_halt_id is ignored in this state.
- DONE:
  - o_pipe_en=0; o_done=1 in the first DONE cycle only.
  - Only ABORT leaves: → IDLE and o_cycle_count cleared to 0.
  - RUN and STEP are accepted and dropped.
- Counter: saturates at all-ones; no wrap.
- Invariant: o_step_ack and o_done are never high together.
- Total enabled cycles for a run whose HALT reaches ID after k RUN cycles = k + DRAIN_CYCLES.

Decomposition:
- Shared package (pipeline_ctrl_pkg) holds:
  - State encoding localparams (IDLE..DONE).
  - Command encoding (CMD_NOP, CMD_RUN, CMD_STEP, CMD_ABORT).
  - Default DRAIN_CYCLES, reused by the debug unit.
- One natural sub-module: exec_cycle_counter, a saturating counter with enable and synchronous clear.

Test Plan:
- Reset, then RUN at cycle 2, i_halt_id pulsed at the 10th enabled cycle, DRAIN_CYCLES=4 → o_pipe_en high for exactly 14 cycles; o_done pulses once; o_cycle_count=14; o_state=4.
- Three consecutive STEP commands, no HALT → three single-cycle o_pipe_en pulses, three o_step_ack pulses; o_cycle_count=3; final state IDLE.
- STEP while i_halt_id=1 → 1+4=5 enabled cycles; o_done pulses; no o_step_ack.
- RUN, then ABORT and i_halt_id=1 in the same cycle → next state IDLE; no DRAIN; count retained; later ABORT from IDLE leaves count unchanged.
- In DONE issue RUN (dropped, stays DONE), then ABORT → IDLE and count=0; i_reset_n asserted mid-DRAIN → all outputs 0 immediately and stay 0 after release.
- CNT_BITS=4, long RUN → count saturates at 15 and holds.
